// File: rtl/rv32v_vreg_file_banked.sv
// RV32V banked vector register file: three registered lane-parallel read ports, one write port, v0 masks,
// post-reset clearing sequencer. Define RV32V_RF_BYPASS_EN to forward same-cycle writes into reads.
module rv32v_vreg_file_banked #(
    parameter int VLEN      = 128,
    parameter int NUM_LANES = 2,
    parameter int NUM_REGS  = 32,
    parameter int OFF_W     = $clog2(VLEN/8)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    output logic                     busy,
    input  logic [4:0]               vs1,
    input  logic [4:0]               vs2,
    input  logic [4:0]               vs3,
    input  logic [OFF_W-1:0]         vs1_offset,
    input  logic [OFF_W-1:0]         vs2_offset,
    input  logic [OFF_W-1:0]         vs3_offset,
    input  logic [1:0]               sew,
    input  logic [1:0]               eew,
    input  logic [OFF_W:0]           vl,
    input  logic [4:0]               vd,
    input  logic [OFF_W-1:0]         vd_offset,
    input  logic                     wen,
    input  logic [NUM_LANES-1:0]     w_lane_en,
    input  logic [NUM_LANES*32-1:0]  w_data,
    output logic [NUM_LANES*32-1:0]  vs1_data,
    output logic [NUM_LANES*32-1:0]  vs2_data,
    output logic [NUM_LANES*32-1:0]  vs3_data,
    output logic [NUM_LANES-1:0]     vs1_mask,
    output logic [NUM_LANES-1:0]     vs2_mask,
    output logic [NUM_LANES-1:0]     vs3_mask
);

    localparam int NBYTES = VLEN / 8;
    localparam int CNT_W  = $clog2(NUM_REGS);
    localparam int BIT_W  = $clog2(VLEN);
`ifdef RV32V_RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {INIT, READY} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [VLEN-1:0]    regs [NUM_REGS];
    logic [NBYTES-1:0]  wr_be;
    logic [VLEN-1:0]    wr_bytes;
    logic [OFF_W-1:0]   idx;
    logic [VLEN-1:0]    src1, src2, src3, src_v0;

    // Shifting the element index left by the width and truncating wraps it inside the register.
    function automatic logic [OFF_W-1:0] byte_addr(input logic [OFF_W-1:0] off, input int lane,
                                                   input logic [1:0] w);
        logic [OFF_W+2:0] e;
        e = (OFF_W+3)'(off) + (OFF_W+3)'(lane);
        return OFF_W'(e << w);
    endfunction

    function automatic logic [31:0] read_elem(input logic [VLEN-1:0] r, input logic [OFF_W-1:0] off,
                                              input int lane, input logic [1:0] w);
        logic [VLEN-1:0] sh;
        sh = r >> {byte_addr(off, lane, w), 3'b000};
        case (w)
            2'd0:    return {24'b0, sh[7:0]};
            2'd1:    return {16'b0, sh[15:0]};
            2'd2:    return sh[31:0];
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic mask_bit(input logic [VLEN-1:0] v0, input logic [OFF_W-1:0] off,
                                      input int lane, input logic [1:0] w);
        logic [BIT_W-1:0] e;
        e = BIT_W'(off) + BIT_W'(lane);
        return (w == 2'd3) ? 1'b0 : v0[e];
    endfunction

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (!clear && cnt == CNT_W'(NUM_REGS-1))
                    state_next = READY;
            end
            READY: begin
                if (clear)
                    state_next = INIT;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (clear || state == READY || cnt == CNT_W'(NUM_REGS-1))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // Byte-granular write plan: only active, enabled, non-tail lanes touch their EEW bytes.
    always_comb begin
        wr_be    = '0;
        wr_bytes = '0;
        idx      = '0;
        if (state == READY && wen && eew != 2'd3) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_lane_en[i] && ((OFF_W+2)'(vd_offset) + (OFF_W+2)'(i) < (OFF_W+2)'(vl))) begin
                    for (int k = 0; k < 4; k++) begin
                        if (k < (1 << eew)) begin
                            idx = byte_addr(vd_offset, i, eew) + OFF_W'(k);
                            wr_be[idx] = 1'b1;
                            wr_bytes[int'(idx)*8 +: 8] = w_data[i*32 + k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        src1   = regs[vs1];
        src2   = regs[vs2];
        src3   = regs[vs3];
        src_v0 = regs[0];
        if (BYPASS) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    if (vs1 == vd) src1[b*8 +: 8] = wr_bytes[b*8 +: 8];
                    if (vs2 == vd) src2[b*8 +: 8] = wr_bytes[b*8 +: 8];
                    if (vs3 == vd) src3[b*8 +: 8] = wr_bytes[b*8 +: 8];
                    if (vd == 5'd0) src_v0[b*8 +: 8] = wr_bytes[b*8 +: 8];
                end
            end
        end
    end

    // Storage is not reset; the INIT sweep clears it one register per cycle.
    always_ff @(posedge CLK) begin
        if (state == INIT) begin
            regs[cnt] <= '0;
        end else begin
            for (int b = 0; b < NBYTES; b++)
                if (wr_be[b])
                    regs[vd][b*8 +: 8] <= wr_bytes[b*8 +: 8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vs1_data <= '0;
            vs2_data <= '0;
            vs3_data <= '0;
            vs1_mask <= '0;
            vs2_mask <= '0;
            vs3_mask <= '0;
        end else if (state == INIT) begin
            vs1_data <= '0;
            vs2_data <= '0;
            vs3_data <= '0;
            vs1_mask <= '0;
            vs2_mask <= '0;
            vs3_mask <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                vs1_data[i*32 +: 32] <= read_elem(src1, vs1_offset, i, sew);
                vs2_data[i*32 +: 32] <= read_elem(src2, vs2_offset, i, sew);
                vs3_data[i*32 +: 32] <= read_elem(src3, vs3_offset, i, sew);
                vs1_mask[i]          <= mask_bit(src_v0, vs1_offset, i, sew);
                vs2_mask[i]          <= mask_bit(src_v0, vs2_offset, i, sew);
                vs3_mask[i]          <= mask_bit(src_v0, vs3_offset, i, sew);
            end
        end
    end

endmodule

// File: tb/tb_rv32v_vreg_file_banked.sv
// Self-checking bench for rv32v_vreg_file_banked: directed scenarios plus random traffic,
// compared every cycle against a byte-array reference model.
module tb_rv32v_vreg_file_banked;

    localparam int VLEN      = 128;
    localparam int NUM_LANES = 2;
    localparam int NUM_REGS  = 32;
    localparam int OFF_W     = 4;
    localparam int NB        = VLEN / 8;

    logic        CLK = 1'b0;
    logic        RST, clear, busy, wen;
    logic [4:0]  vs1, vs2, vs3, vd;
    logic [3:0]  vs1_offset, vs2_offset, vs3_offset, vd_offset;
    logic [1:0]  sew, eew;
    logic [4:0]  vl;
    logic [1:0]  w_lane_en;
    logic [63:0] w_data, vs1_data, vs2_data, vs3_data;
    logic [1:0]  vs1_mask, vs2_mask, vs3_mask;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [NUM_REGS][NB];
    bit         modelReady = 1'b0;
    int         modelCnt   = 0;

    rv32v_vreg_file_banked #(.VLEN(VLEN), .NUM_LANES(NUM_LANES), .NUM_REGS(NUM_REGS), .OFF_W(OFF_W)) dut (
        .CLK(CLK), .RST(RST), .clear(clear), .busy(busy),
        .vs1(vs1), .vs2(vs2), .vs3(vs3),
        .vs1_offset(vs1_offset), .vs2_offset(vs2_offset), .vs3_offset(vs3_offset),
        .sew(sew), .eew(eew), .vl(vl), .vd(vd), .vd_offset(vd_offset),
        .wen(wen), .w_lane_en(w_lane_en), .w_data(w_data),
        .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data),
        .vs1_mask(vs1_mask), .vs2_mask(vs2_mask), .vs3_mask(vs3_mask)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // {hit, byte} that the pending write puts into byte b of register r, if any.
    function automatic logic [8:0] pendingByte(input int r, input int b);
        logic [8:0] res;
        int nb, ne, e;
        res = 9'b0;
        if (!modelReady || !wen || eew == 2'd3 || r != int'(vd)) return res;
        nb = 1 << eew;
        ne = NB / nb;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_lane_en[i] && (int'(vd_offset) + i < int'(vl))) begin
                e = (int'(vd_offset) + i) % ne;
                if (b >= e*nb && b < e*nb + nb)
                    res = {1'b1, w_data[i*32 + (b - e*nb)*8 +: 8]};
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] readByte(input int r, input int b);
`ifdef RV32V_RF_BYPASS_EN
        logic [8:0] pb;
        pb = pendingByte(r, b);
        if (pb[8]) return pb[7:0];
`endif
        return mem[r][b];
    endfunction

    function automatic logic [63:0] expData(input int r, input int off, input logic [1:0] w);
        logic [63:0] res;
        logic [31:0] val;
        int nb, e;
        res = 64'b0;
        if (w == 2'd3) return res;
        nb = 1 << w;
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            e   = (off + lane) % (NB / nb);
            val = 32'b0;
            for (int k = 0; k < nb; k++)
                val = val | (32'(readByte(r, e*nb + k)) << (8*k));
            res[lane*32 +: 32] = val;
        end
        return res;
    endfunction

    function automatic logic [1:0] expMask(input int off, input logic [1:0] w);
        logic [1:0] res;
        logic [7:0] by;
        res = 2'b0;
        if (w == 2'd3) return res;
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            by = readByte(0, (off + lane) / 8);
            res[lane] = by[(off + lane) % 8];
        end
        return res;
    endfunction

    // One clock: predict registered reads, advance the model, then compare after the edge.
    task automatic tick();
        logic [63:0] e1, e2, e3;
        logic [1:0]  m1, m2, m3;
        logic [8:0]  pb;
        e1 = '0; e2 = '0; e3 = '0; m1 = '0; m2 = '0; m3 = '0;
        if (!RST && modelReady) begin
            e1 = expData(int'(vs1), int'(vs1_offset), sew);
            e2 = expData(int'(vs2), int'(vs2_offset), sew);
            e3 = expData(int'(vs3), int'(vs3_offset), sew);
            m1 = expMask(int'(vs1_offset), sew);
            m2 = expMask(int'(vs2_offset), sew);
            m3 = expMask(int'(vs3_offset), sew);
        end
        if (RST) begin
            modelReady = 1'b0;
            modelCnt   = 0;
        end else if (!modelReady) begin
            for (int b = 0; b < NB; b++) mem[modelCnt][b] = 8'h00;
            if (clear) modelCnt = 0;
            else if (modelCnt == NUM_REGS-1) begin modelReady = 1'b1; modelCnt = 0; end
            else modelCnt++;
        end else begin
            for (int b = 0; b < NB; b++) begin
                pb = pendingByte(int'(vd), b);
                if (pb[8]) mem[vd][b] = pb[7:0];
            end
            if (clear) begin modelReady = 1'b0; modelCnt = 0; end
        end
        @(posedge CLK);
        #1;
        checkOutput("busy", 64'(busy), 64'(!modelReady));
        checkOutput("vs1_data", vs1_data, e1);
        checkOutput("vs2_data", vs2_data, e2);
        checkOutput("vs3_data", vs3_data, e3);
        checkOutput("vs1_mask", 64'(vs1_mask), 64'(m1));
        checkOutput("vs2_mask", 64'(vs2_mask), 64'(m2));
        checkOutput("vs3_mask", 64'(vs3_mask), 64'(m3));
    endtask

    task automatic driveWrite(input int r, input int w, input int off, input int len,
                              input logic [1:0] lanes, input logic [63:0] data);
        wen = 1'b1; vd = 5'(r); eew = 2'(w); vd_offset = 4'(off); vl = 5'(len);
        w_lane_en = lanes; w_data = data;
    endtask

    task automatic driveRead(input int r, input int w, input int o1, input int o2, input int o3);
        vs1 = 5'(r); vs2 = 5'(r); vs3 = 5'(r); sew = 2'(w);
        vs1_offset = 4'(o1); vs2_offset = 4'(o2); vs3_offset = 4'(o3);
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
            wen = 1'b0;
        end
        checkOutput(tag, 64'(n), 64'd32);
    endtask

    task automatic applyStimulus();
        clear = ($urandom_range(0, 149) == 0);
        wen = $urandom_range(0, 1) == 1;
        vd = 5'($urandom_range(0, 7));
        eew = 2'($urandom_range(0, 3));
        vd_offset = 4'($urandom_range(0, 15));
        vl = 5'($urandom_range(0, 16));
        w_lane_en = 2'($urandom_range(0, 3));
        w_data = {$urandom, $urandom};
        vs1 = 5'($urandom_range(0, 7));
        vs2 = 5'($urandom_range(0, 7));
        vs3 = 5'($urandom_range(0, 7));
        sew = 2'($urandom_range(0, 3));
        vs1_offset = 4'($urandom_range(0, 15));
        vs2_offset = 4'($urandom_range(0, 15));
        vs3_offset = 4'($urandom_range(0, 15));
    endtask

    initial begin
        RST = 1'b1; clear = 1'b0; wen = 1'b0; vd = '0; eew = '0; vd_offset = '0; vl = '0;
        w_lane_en = '0; w_data = '0;
        driveRead(0, 0, 0, 0, 0);
        for (int i = 0; i < NUM_REGS; i++)
            for (int b = 0; b < NB; b++) mem[i][b] = 8'hXX;
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd1);
        checkOutput("reset_data", vs1_data, 64'd0);
        tick();
        tick();
        RST = 1'b0;
        waitReady("init_cycles");

        driveRead(5, 2, 0, 0, 0);
        tick();
        checkOutput("v5_zero", vs1_data, 64'd0);

        driveWrite(3, 2, 2, 4, 2'b11, {32'hDEADBEEF, 32'h12345678});
        tick();
        wen = 1'b0;
        driveRead(3, 2, 2, 2, 2);
        tick();
        checkOutput("v3_sew32", vs1_data, {32'hDEADBEEF, 32'h12345678});
        driveRead(3, 0, 8, 8, 8);
        tick();
        checkOutput("v3_sew8", vs1_data, {32'h00000056, 32'h00000078});

        driveWrite(4, 2, 2, 4, 2'b11, {32'hAAAAAAAA, 32'hAAAAAAAA});
        tick();
        driveWrite(4, 2, 2, 3, 2'b11, {32'h11111111, 32'h22222222});
        tick();
        wen = 1'b0;
        driveRead(4, 2, 2, 2, 2);
        tick();
        checkOutput("v4_tail", vs1_data, {32'hAAAAAAAA, 32'h22222222});

        driveWrite(0, 0, 0, 4, 2'b11, {32'h00000000, 32'h00000005});
        tick();
        wen = 1'b0;
        driveRead(0, 0, 0, 2, 1);
        tick();
        checkOutput("mask_off0", 64'(vs1_mask), 64'(2'b01));
        checkOutput("mask_off2", 64'(vs2_mask), 64'(2'b01));
        checkOutput("mask_off1", 64'(vs3_mask), 64'(2'b10));

        driveWrite(7, 0, 0, 16, 2'b01, {32'h0, 32'h00000011});
        driveRead(7, 0, 0, 0, 0);
        tick();
        wen = 1'b0;
`ifdef RV32V_RF_BYPASS_EN
        checkOutput("collide_v7", vs1_data, 64'h11);
`else
        checkOutput("collide_v7", vs1_data, 64'h0);
`endif
        tick();
        checkOutput("after_v7", vs1_data, 64'h11);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        driveWrite(9, 2, 0, 16, 2'b11, {32'hFFFFFFFF, 32'hFFFFFFFF});
        waitReady("clear_cycles");
        for (int r = 0; r < NUM_REGS; r++) begin
            driveRead(r, 2, 0, 1, 2);
            tick();
            checkOutput("cleared", vs1_data | vs2_data | vs3_data, 64'd0);
        end

        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        waitReady("rst_mid_init");

        for (int n = 0; n < 600; n++) begin
            applyStimulus();
            tick();
        end
        clear = 1'b0;
        wen = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32v_vreg_file_banked.md
Name: rv32v_vreg_file_banked

Overview:
- Parametrised vector register file for the RV32V pipeline; successor to the fixed two-lane register-file contract.
- Provides three lane-parallel read ports (vs1/vs2/vs3), one lane-parallel write port, and per-element v0 mask extraction.
- Element packing follows SEW (reads) and EEW (writes).
- Adds a post-reset clearing sequencer, tail-suppressed writes and per-lane write enables.
- Read data is registered.
- Sits between vector decode (reads) and vector writeback (writes).

Parameters:
- VLEN, 128, bits per vector register (power of two, ≥64).
- NUM_LANES, 2, elements read/written per cycle per port (power of two, ≤ VLEN/32).
- NUM_REGS, 32, architectural vector registers.
- OFF_W, $clog2(VLEN/8), element offset width.

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous active-high reset
- clear  input  1  pulse: re-run clearing sequence
- busy  output  1  clearing in progress
- vs1, vs2, vs3  input  5 each  source register indices
- vs1_offset, vs2_offset, vs3_offset  input  OFF_W each  element index of lane 0
- sew  input  2  read element width: 0=8, 1=16, 2=32
- eew  input  2  write element width, same encoding
- vl  input  OFF_W+1  active vector length in elements
- vd  input  5  destination register
- vd_offset  input  OFF_W  element index of write lane 0
- wen  input  1  write request
- w_lane_en  input  NUM_LANES  per-lane write enable
- w_data  input  NUM_LANES×32  write elements, low EEW bits used
- vs1_data, vs2_data, vs3_data  output  NUM_LANES×32  zero-extended elements
- vs1_mask, vs2_mask, vs3_mask  output  NUM_LANES  v0 bit for each lane's element index

Behaviour:
- Clock/reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Storage: NUM_REGS × VLEN bits.
- Element addressing:
  - Lane i element index e = offset + i.
  - Byte address = e << width. Element occupies bytes [addr, addr + 2^width).
  - Index modulo VLEN/(8·2^width) wraps within the register; no spill into the next register.
- Reads:
  - Registered; outputs valid the cycle after inputs are presented (1-cycle latency).
  - Data zero-extended to 32 bits.
  - mask[i] = v0 bit e (one mask bit per element, independent of sew).
  - sew=3 (reserved): data and mask read as 0.
- Writes (on rising CLK):
  - Lane i writes when wen & w_lane_en[i] & (vd_offset+i < vl) & state==READY.
  - Only the EEW bytes of that element change. All other bytes are undisturbed (tail/inactive-undisturbed).
  - eew=3: no write.
- Read/write collision:
  - Same-cycle write and read of the same register element: the read returns the old value unless RV32V_RF_BYPASS_EN is defined.
  - Writes to v0 update mask outputs on the next registered read.
- FSM states: INIT, READY.
  - RST asserted → INIT, clear counter = 0, all read/mask outputs 0, busy = 1.
  - INIT: zero register[counter] each cycle; counter increments; after register NUM_REGS-1 is zeroed → READY. Takes NUM_REGS cycles.
  - INIT: writes dropped; read outputs forced to 0.
  - READY: busy = 0. clear=1 → INIT, counter = 0.
  - clear during INIT restarts the counter at 0.
  - RST mid-INIT restarts the sequence.
- Reset values: busy = 1; vs*_data = 0; vs*_mask = 0.

Optional Feature:
- Macro: RV32V_RF_BYPASS_EN.
- Defined:
  - When a write and a read target the same vd and overlapping bytes in one cycle, the registered read returns the newly written bytes.
  - Forwarding is per byte and honours lane enable, tail and eew rules.
  - Mask outputs also forward writes to v0.
- Undefined: no forwarding; the read returns pre-write contents.

Test Plan:
- RST pulse, then idle → busy=1 for 32 cycles, then 0; read v5 offset 0 sew=2 → both lanes 0x00000000.
- Write v3, eew=2, vd_offset=2, vl=4, w_data={0xDEADBEEF,0x12345678}, lanes 11 → read sew=2 offset 2 returns lane0=0x12345678, lane1=0xDEADBEEF. Read sew=0 offset 8 returns 0x78, 0x56.
- Tail: write v4, eew=2, vd_offset=2, vl=3, lanes 11 → only element 2 changes; element 3 keeps its prior value 0xAAAAAAAA.
- Write v0, eew=0, vd_offset=0, data {0x05,0x00} → vs1_mask for offset 0 = 2'b01, offset 2 = 2'b01, offset 1 = 2'b10.
- Same-cycle write v7 elem 0 = 0x11 and read v7 elem 0 → 0x11 with RV32V_RF_BYPASS_EN, old value 0x00 without.
- clear asserted while READY after writes → busy=1 for 32 cycles; a write issued during INIT is dropped; all registers read 0 afterwards.
